keycode_ctrl: RTL and testbench

//  Consumes the 8-bit USB HID keycode exported by the Nios/USB subsystem (keycode_export)
//  and turns it into debounced, game-ready player controls for the Galaga game logic.

---
 rtl/keycode_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_keycode_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_ctrl.sv
// -----------------------------------------------------------------------------
// keycode_ctrl
//   Turns the raw 8-bit USB HID keycode from the Nios/USB subsystem into
//   debounced, game-ready player controls for the Galaga game logic.
//   A keycode must hold steady before it is accepted. The accepted code is
//   decoded into move/fire/start/pause keys. Shots are rate-limited in video
//   frames, and a pause state is held.
//
// Parameters
//   STABLE_CYCLES  consecutive clocks a keycode must hold before acceptance
//   FIRE_COOLDOWN  frame_ticks that must elapse after a shot before the next
//
// Build option
//   KEYCODE_CTRL_AUTOFIRE_EN  when defined, holding Space fires repeatedly,
//                             once every time the cooldown expires. When not
//                             defined, each press gives exactly one shot.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   keycode_in     in   raw HID keycode, 8'h00 = no key
//   frame_tick     in   one-clock pulse per video frame
//   move_left      out  level: left key held while the game is running
//   move_right     out  level: right key held while the game is running
//   fire_pulse     out  one-clock pulse: spawn a player missile
//   start_pulse    out  one-clock pulse: Enter pressed
//   paused         out  level: game paused
//   kc_stable      out  accepted (debounced) keycode, for debug display
// -----------------------------------------------------------------------------
module keycode_ctrl #(
    parameter int STABLE_CYCLES = 1000,
    parameter int FIRE_COOLDOWN = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode_in,
    input  logic       frame_tick,
    output logic       move_left,
    output logic       move_right,
    output logic       fire_pulse,
    output logic       start_pulse,
    output logic       paused,
    output logic [7:0] kc_stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(FIRE_COOLDOWN);

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_P     = 8'h13;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;

    // Key decode helpers. There is only one keycode, so at most one is true.
    function automatic logic is_left(input logic [7:0] kc);
        return (kc == KC_A) || (kc == KC_LEFT);
    endfunction

    function automatic logic is_right(input logic [7:0] kc);
        return (kc == KC_D) || (kc == KC_RIGHT);
    endfunction

    // Filter state
    logic [7:0]       kc_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       kc_stable_r;

    // Edge-detect and control state
    logic             fire_q_r;
    logic             pause_q_r;
    logic             start_q_r;
    logic             paused_r;
    logic [CD_W-1:0]  cooldown_r;

    // Registered outputs
    logic             move_left_r;
    logic             move_right_r;
    logic             fire_pulse_r;
    logic             start_pulse_r;

    // Decode results
    logic             left_s;
    logic             right_s;
    logic             fire_s;
    logic             pause_s;
    logic             start_s;
    logic             shot_s;

    // Debounce filter: a keycode is accepted only after it has held long enough.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            kc_q_r      <= 8'h00;
            cnt_r       <= '0;
            kc_stable_r <= 8'h00;
        end else begin
            kc_q_r <= keycode_in;
            if (keycode_in != kc_q_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (cnt_r == CNT_MAX) begin
                kc_stable_r <= kc_q_r;
            end
        end
    end

    // Key decode from the accepted keycode, plus the shot condition.
    always_comb begin
        left_s  = is_left(kc_stable_r);
        right_s = is_right(kc_stable_r);
        fire_s  = (kc_stable_r == KC_SPACE);
        pause_s = (kc_stable_r == KC_P);
        start_s = (kc_stable_r == KC_ENTER);
`ifdef KEYCODE_CTRL_AUTOFIRE_EN
        // Level-sensitive: a held key re-fires whenever the cooldown reaches zero.
        shot_s  = fire_s;
`else
        // Edge-sensitive: one shot per press, however long the key is held.
        shot_s  = fire_s & ~fire_q_r;
`endif
    end

    // Player controls: edge tracking, pause toggle, movement, start and rate-limited fire.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fire_q_r      <= 1'b0;
            pause_q_r     <= 1'b0;
            start_q_r     <= 1'b0;
            paused_r      <= 1'b0;
            cooldown_r    <= '0;
            move_left_r   <= 1'b0;
            move_right_r  <= 1'b0;
            fire_pulse_r  <= 1'b0;
            start_pulse_r <= 1'b0;
        end else begin
            // Edges are tracked even while paused, so a key held across
            // pause/unpause is not seen as a fresh press.
            fire_q_r  <= fire_s;
            pause_q_r <= pause_s;
            start_q_r <= start_s;

            // Gating uses the registered pause, so a toggle takes effect on the next edge.
            move_left_r   <= left_s & ~paused_r;
            move_right_r  <= right_s & ~paused_r;
            start_pulse_r <= start_s & ~start_q_r;

            if (pause_s && !pause_q_r) begin
                paused_r <= ~paused_r;
            end

            // The cooldown is frozen while paused. A press during the cooldown is dropped.
            // The shot test uses the registered cooldown, so nothing fires on the
            // edge where the count reaches zero.
            if (!paused_r) begin
                if (shot_s && (cooldown_r == '0)) begin
                    fire_pulse_r <= 1'b1;
                    cooldown_r   <= CD_LOAD;
                end else begin
                    fire_pulse_r <= 1'b0;
                    if (frame_tick && (cooldown_r != '0)) begin
                        cooldown_r <= cooldown_r - CD_W'(1);
                    end
                end
            end else begin
                fire_pulse_r <= 1'b0;
            end
        end
    end

    assign move_left   = move_left_r;
    assign move_right  = move_right_r;
    assign fire_pulse  = fire_pulse_r;
    assign start_pulse = start_pulse_r;
    assign paused      = paused_r;
    assign kc_stable   = kc_stable_r;

endmodule

// File: tb/tb_keycode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keycode_ctrl
//   Directed, table-driven bench for keycode_ctrl with STABLE_CYCLES=4 and
//   FIRE_COOLDOWN=3.
//   Each table row applies keycode_in and frame_tick for a fixed number of
//   edges. It counts fire and start pulses during the row, and it compares
//   the levels seen after the last edge.
//   Hand-written sequences cover a held Space, and reset during a cooldown.
//   A change applied before edge 1 of a row reaches kc_stable at edge 6.
//   The outputs follow at edge 7.
// -----------------------------------------------------------------------------
module tb_keycode_ctrl;

    localparam int STABLE = 4;
    localparam int COOL   = 3;

    logic       clk_clk;
    logic       reset_reset_n;
    logic [7:0] keycode_in;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       fire_pulse;
    logic       start_pulse;
    logic       paused;
    logic [7:0] kc_stable;

    int checks = 0;
    int errors = 0;

    keycode_ctrl #(
        .STABLE_CYCLES (STABLE),
        .FIRE_COOLDOWN (COOL)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keycode_in    (keycode_in),
        .frame_tick    (frame_tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .fire_pulse    (fire_pulse),
        .start_pulse   (start_pulse),
        .paused        (paused),
        .kc_stable     (kc_stable)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    typedef struct {
        logic [7:0] kc;    // keycode driven for the whole row
        logic       ft;    // frame_tick level for the whole row
        int         cyc;   // edges in this row
        logic       ml;    // expected move_left after the last edge
        logic       mr;    // expected move_right after the last edge
        logic       pz;    // expected paused after the last edge
        logic [7:0] kcs;   // expected kc_stable after the last edge
        int         nf;    // expected fire_pulse count within the row
        int         ns;    // expected start_pulse count within the row
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];

    function automatic vec_t mk(input logic [7:0] kc, input logic ft, input int cyc,
                                input logic ml, input logic mr, input logic pz,
                                input logic [7:0] kcs, input int nf, input int ns);
        vec_t v;
        v.kc = kc; v.ft = ft; v.cyc = cyc; v.ml = ml; v.mr = mr;
        v.pz = pz; v.kcs = kcs; v.nf = nf; v.ns = ns;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        int nf;
        int ns;
        nf = 0;
        ns = 0;
        keycode_in = v.kc;
        frame_tick = v.ft;
        repeat (v.cyc) begin
            @(posedge clk_clk);
            #1;
            nf += int'(fire_pulse);
            ns += int'(start_pulse);
        end
        chk($sformatf("%s[%0d] move_left", tag, idx),  {31'd0, move_left},  {31'd0, v.ml});
        chk($sformatf("%s[%0d] move_right", tag, idx), {31'd0, move_right}, {31'd0, v.mr});
        chk($sformatf("%s[%0d] paused", tag, idx),     {31'd0, paused},     {31'd0, v.pz});
        chk($sformatf("%s[%0d] kc_stable", tag, idx),  {24'd0, kc_stable},  {24'd0, v.kcs});
        chk($sformatf("%s[%0d] fire_count", tag, idx), nf, v.nf);
        chk($sformatf("%s[%0d] start_count", tag, idx), ns, v.ns);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " move_left"},   {31'd0, move_left},   32'd0);
        chk({tag, " move_right"},  {31'd0, move_right},  32'd0);
        chk({tag, " fire_pulse"},  {31'd0, fire_pulse},  32'd0);
        chk({tag, " start_pulse"}, {31'd0, start_pulse}, 32'd0);
        chk({tag, " paused"},      {31'd0, paused},      32'd0);
        chk({tag, " kc_stable"},   {24'd0, kc_stable},   32'd0);
    endtask

    initial begin
        int nf;
        int exp_hold;
        int first_fire;

        // ------------------------------------------------------------------
        // Tables: kc, ft, cyc, ml, mr, pz, kcs, nf, ns
        // ------------------------------------------------------------------
        // Movement, glitch rejection, fire cooldown, pause
        tab1.push_back(mk(8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // idle after reset
        tab1.push_back(mk(8'h04, 1'b0, 6, 1'b0, 1'b0, 1'b0, 8'h04, 0, 0)); // A accepted at edge 6
        tab1.push_back(mk(8'h04, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h04, 0, 0)); // move_left at edge 7
        tab1.push_back(mk(8'h00, 1'b0, 6, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0)); // release, still moving
        tab1.push_back(mk(8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // drops 7 edges later
        tab1.push_back(mk(8'h4F, 1'b0, 7, 1'b0, 1'b1, 1'b0, 8'h4F, 0, 0)); // Right arrow
        tab1.push_back(mk(8'h50, 1'b0, 6, 1'b0, 1'b1, 1'b0, 8'h50, 0, 0)); // Right->Left, no gap
        tab1.push_back(mk(8'h50, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h50, 0, 0)); // swap on one edge
        tab1.push_back(mk(8'h07, 1'b0, 7, 1'b0, 1'b1, 1'b0, 8'h07, 0, 0)); // D key
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h2C, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // 3-clock glitch
        tab1.push_back(mk(8'h00, 1'b0, 10, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // discarded
        tab1.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 1, 0)); // Space fires, cd=3
        tab1.push_back(mk(8'h2C, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h2C, 0, 0)); // held: no refire
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // tick: cd=2
        tab1.push_back(mk(8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // tick: cd=1
        tab1.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 0, 0)); // press dropped
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // tick: cd=0
        tab1.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 1, 0)); // fires again, cd=3
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h13, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h13, 0, 0)); // P: pause
        tab1.push_back(mk(8'h04, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h04, 0, 0)); // A gated
        tab1.push_back(mk(8'h04, 1'b1, 5, 1'b0, 1'b0, 1'b1, 8'h04, 0, 0)); // 5 ticks ignored
        tab1.push_back(mk(8'h13, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h13, 0, 0)); // P: unpause
        tab1.push_back(mk(8'h04, 1'b0, 7, 1'b1, 1'b0, 1'b0, 8'h04, 0, 0)); // A moves again
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 0, 0)); // cd still 3
        tab1.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab1.push_back(mk(8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // cd 3 -> 0
        tab1.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 1, 0)); // press; held next

        // Start key, start while paused, no fire while paused, setup for reset
        tab2.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab2.push_back(mk(8'h28, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h28, 0, 1)); // Enter pulse
        tab2.push_back(mk(8'h28, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h28, 0, 0)); // held: one only
        tab2.push_back(mk(8'h13, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h13, 0, 0)); // pause
        tab2.push_back(mk(8'h28, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h28, 0, 1)); // start while paused
        tab2.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h2C, 0, 0)); // no fire paused
        tab2.push_back(mk(8'h13, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h13, 0, 0)); // unpause
        tab2.push_back(mk(8'h00, 1'b1, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0)); // drain cooldown
        tab2.push_back(mk(8'h2C, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h2C, 1, 0)); // fire, cd=3
        tab2.push_back(mk(8'h00, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0));
        tab2.push_back(mk(8'h13, 1'b0, 7, 1'b0, 1'b0, 1'b1, 8'h13, 0, 0)); // paused mid-cooldown

        // ------------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------------
        reset_reset_n = 1'b0;
        keycode_in    = 8'h00;
        frame_tick    = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;

        for (int i = 0; i < tab1.size(); i++) run_vec("tab1", i, tab1[i]);

        // ------------------------------------------------------------------
        // Space held for 10 frames. Autofire re-fires on the edge after every
        // 3rd tick.
        // ------------------------------------------------------------------
`ifdef KEYCODE_CTRL_AUTOFIRE_EN
        exp_hold = 3;
`else
        exp_hold = 0;
`endif
        nf = 0;
        keycode_in = 8'h2C;
        for (int fr = 0; fr < 10; fr++) begin
            frame_tick = 1'b1;
            @(posedge clk_clk);
            #1;
            nf += int'(fire_pulse);
            frame_tick = 1'b0;
            repeat (3) begin
                @(posedge clk_clk);
                #1;
                nf += int'(fire_pulse);
            end
        end
        chk("held_space total_pulses", 1 + nf, 1 + exp_hold);

        for (int i = 0; i < tab2.size(); i++) run_vec("tab2", i, tab2[i]);

        // ------------------------------------------------------------------
        // Reset while paused and mid-cooldown, with Space held through it.
        // ------------------------------------------------------------------
        keycode_in = 8'h2C;
        repeat (2) @(posedge clk_clk);
        #1;
        chk("pre_reset paused", {31'd0, paused}, 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk_clk);
        #1;
        chk_all_zero("held_reset");
        reset_reset_n = 1'b1;
        first_fire = 0;
        nf = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk_clk);
            #1;
            if (e == 5) chk("post_reset kc_stable@5", {24'd0, kc_stable}, 32'h00);
            if (e == 6) chk("post_reset kc_stable@6", {24'd0, kc_stable}, 32'h2C);
            if (fire_pulse && first_fire == 0) first_fire = e;
            nf += int'(fire_pulse);
        end
        chk("post_reset first_fire_edge", first_fire, 7);
        chk("post_reset fire_count", nf, 1);
        chk("post_reset paused", {31'd0, paused}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
